// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants, FSM states and address decode for the register file writer
package reg_file_pkg;

  localparam int NUM_REGS = 5;
  localparam int REG_W = 3;
  localparam logic [NUM_REGS-1:0] ONEHOT_RST = 5'b00001;
  localparam logic [2:0] MAX_ADDR = 3'(NUM_REGS - 1);

  typedef enum logic {
    IDLE,
    COMMIT
  } state_t;

  // Out-of-range addresses decode to an all-zero strobe so they can never write
  function automatic logic [NUM_REGS-1:0] bin2onehot(input logic [2:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (addr <= MAX_ADDR) begin
      v = NUM_REGS'(1) << addr;
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_file_writer_onehot_ring.sv
// rtl/reg_file_writer_onehot_ring.sv - scan divider plus rotating one-hot choice register
// load overrides a coincident rotation and restarts the hold period.
module onehot_ring
  import reg_file_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NUM_REGS-1:0] load_val,
  output logic [NUM_REGS-1:0] choice
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  logic [CW-1:0]       r_cnt;
  logic [NUM_REGS-1:0] r_choice;
  logic                w_onehot;

  // A corrupted choice (zero or multi-hot) recovers at the next rotation
  assign w_onehot = (r_choice != '0) && ((r_choice & (r_choice - NUM_REGS'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_choice <= ONEHOT_RST;
    end else if (load) begin
      r_cnt    <= '0;
      r_choice <= load_val;
    end else if (r_cnt == TERM) begin
      r_cnt    <= '0;
      r_choice <= w_onehot ? {r_choice[NUM_REGS-2:0], r_choice[NUM_REGS-1]} : ONEHOT_RST;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign choice = r_choice;

endmodule

// File: rtl/reg_file_writer.sv
// rtl/reg_file_writer.sv - 5x3 register file with handshaked writes and one-hot display scan
// Optional WR_FOLLOW_EN: a legal write moves the scan to the written entry.
module reg_file_writer
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_W,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [2:0]          wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_err,
  output logic [DATA_W-1:0]   option0,
  output logic [DATA_W-1:0]   option1,
  output logic [DATA_W-1:0]   option2,
  output logic [DATA_W-1:0]   option3,
  output logic [DATA_W-1:0]   option4,
  output logic [NUM_REGS-1:0] choice
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_transfer;
  logic                w_commit;
  logic                w_load;
  logic [NUM_REGS-1:0] w_load_val;
  logic [NUM_REGS-1:0] r_strobe;
  logic [DATA_W-1:0]   r_data;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    wr_err      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        wr_err      = r_illegal;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_transfer = wr_valid & wr_ready;

  // Request is captured on the transfer edge and applied on the COMMIT-exit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe  <= '0;
      r_data    <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_transfer) begin
        r_strobe  <= bin2onehot(wr_addr);
        r_data    <= wr_data;
        r_illegal <= (wr_addr > MAX_ADDR);
      end
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_strobe[i]) begin
            r_regs[i] <= r_data;
          end
        end
      end
    end
  end

`ifdef WR_FOLLOW_EN
  assign w_load     = w_commit & ~r_illegal;
  assign w_load_val = r_strobe;
`else
  assign w_load     = 1'b0;
  assign w_load_val = ONEHOT_RST;
`endif

  onehot_ring #(
    .SCAN_DIV(SCAN_DIV)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .choice   (choice)
  );

  assign option0 = r_regs[0];
  assign option1 = r_regs[1];
  assign option2 = r_regs[2];
  assign option3 = r_regs[3];
  assign option4 = r_regs[4];

endmodule

// File: tb/tb_reg_file_writer.sv
// tb/tb_reg_file_writer.sv - scoreboard bench for reg_file_writer (both WR_FOLLOW_EN builds)
module tb_reg_file_writer;

  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [2:0] addr;
    logic [2:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_err;
  logic [2:0] option0, option1, option2, option3, option4;
  logic [4:0] choice;
  logic [2:0] opt [5];

  int         n_cmp;
  int         n_err;
  wr_t        q[$];
  logic [2:0] m_reg [5];
  logic [4:0] m_choice;
  int         m_cnt;
  bit         m_busy;
  bit         last_xfer;

  reg_file_writer #(
    .DATA_W   (3),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .option0  (option0),
    .option1  (option1),
    .option2  (option2),
    .option3  (option3),
    .option4  (option4),
    .choice   (choice)
  );

  assign opt[0] = option0;
  assign opt[1] = option1;
  assign opt[2] = option2;
  assign opt[3] = option3;
  assign opt[4] = option4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic exp_err;
    exp_err = m_busy ? (q[0].addr > 3'd4) : 1'b0;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, !m_busy});
    chk("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("option%0d", i), {29'b0, opt[i]}, {29'b0, m_reg[i]});
    end
    chk("choice", {27'b0, choice}, {27'b0, m_choice});
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 5; i++) m_reg[i] = 3'd0;
    m_choice = 5'b00001;
    m_cnt    = 0;
    m_busy   = 1'b0;
  endtask

  // One clock: advance the model across the edge, then compare everything
  task automatic tick();
    bit  xfer;
    bit  follow;
    wr_t e;
    xfer   = wr_valid && !m_busy;
    follow = 1'b0;
    @(posedge clk);
    if (m_busy) begin
      e = q.pop_front();
      if (e.addr <= 3'd4) begin
        m_reg[e.addr] = e.data;
`ifdef WR_FOLLOW_EN
        m_choice = 5'b00001 << e.addr;
        m_cnt    = 0;
        follow   = 1'b1;
`endif
      end
      m_busy = 1'b0;
    end else if (xfer) begin
      e.addr = wr_addr;
      e.data = wr_data;
      q.push_back(e);
      m_busy = 1'b1;
    end
    if (!follow) begin
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt    = 0;
        m_choice = {m_choice[3:0], m_choice[4]};
      end else begin
        m_cnt++;
      end
    end
    last_xfer = xfer;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic single_write(input logic [2:0] a, input logic [2:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_addr  = 3'($urandom_range(0, 7));
    wr_data  = 3'($urandom_range(0, 7));
    tick();
    tick();
  endtask

  initial begin
    logic [2:0] bb_a [3];
    logic [2:0] bb_d [3];
    int idx;
    int guard;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 3'd0;
    last_xfer = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // free-running scan
    repeat (24) tick();

    // mid-scan reset
    repeat (2) tick();
    do_reset();

    // WR_FOLLOW_EN scenario: write entry 3 while choice is 00001
    single_write(3'd3, 3'b011);
    repeat (8) tick();

    single_write(3'd2, 3'b101);
    single_write(3'd4, 3'b111);

    // back-to-back requests with wr_valid held high
    bb_a[0] = 3'd0; bb_d[0] = 3'b011;
    bb_a[1] = 3'd1; bb_d[1] = 3'b110;
    bb_a[2] = 3'd3; bb_d[2] = 3'b001;
    idx   = 0;
    guard = 0;
    wr_valid = 1'b1;
    while (idx < 3 && guard < 20) begin
      wr_addr = bb_a[idx];
      wr_data = bb_d[idx];
      tick();
      if (last_xfer) idx++;
      guard++;
    end
    wr_valid = 1'b0;
    chk("bb_accepted", idx, 3);
    chk("bb_cycles", guard, 5);
    tick();
    tick();

    // illegal address
    single_write(3'd6, 3'b010);
    single_write(3'd7, 3'b111);
    repeat (3) tick();

    // reset while a request is in COMMIT discards it
    wr_addr  = 3'd1;
    wr_data  = 3'b100;
    wr_valid = 1'b1;
    tick();
    do_reset();
    repeat (6) tick();

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
